layer_stream_serializer: RTL and testbench
==========================================

// Module: layer_stream_serializer
// PURPOSE
//  Parametrised inter-layer serializer: captures a layer's parallel output vector
//  (NUM_WORDS x DATA_WIDTH) and streams it, LANES words per beat, to the next layer
//  or to the readback path. Uses a valid/ready handshake with backpressure, a
//  last-beat marker and a keep mask, plus an optional shadow buffer for
//  back-to-back vectors and a sticky overflow flag. Sits between each Layer_N and Layer_N+1.
// PARAMETERS
//  NUM_WORDS   30  neurons (words) per captured vector, >=1
//  DATA_WIDTH  16  bits per word
//  LANES       1   words per output beat, 1..NUM_WORDS
//  BUFFERED    1   1: one-deep shadow vector register; 0: none
// PORTS
//  s_axi_aclk     in   1                    clock
//  s_axi_aresetn  in   1                    async active-low reset
//  soft_reset     in   1                    sync clear, same effect as reset
//  i_valid        in   1                    capture strobe for i_data (1 cycle)
//  i_data         in   NUM_WORDS*DATA_WIDTH word 0 at LSBs
//  o_data         out  LANES*DATA_WIDTH     lane k = word beat*LANES+k; pad lanes 0
//  o_keep         out  LANES                1 = lane holds a real word
//  o_valid        out  1                    beat valid
//  o_ready        in   1                    sink accepts beat
//  o_last         out  1                    final beat of vector
//  busy           out  1                    state==SEND or shadow full
//  overflow       out  1                    sticky: a vector was dropped
// BEHAVIOUR
//  Clock is s_axi_aclk. Reset is asynchronous and active-low on s_axi_aresetn.
//  Reset or soft_reset: o_valid=0, o_last=0, o_keep=0, o_data=0, busy=0,
//   overflow=0, shadow empty, beat=0, state IDLE. In-flight vectors are discarded.
//  NUM_BEATS = ceil(NUM_WORDS/LANES); REM = NUM_WORDS-(NUM_BEATS-1)*LANES.
//  Transfer = o_valid && o_ready. All outputs are registered.
//  IDLE: on i_valid, capture into the active register, beat=0, go to SEND.
//   o_valid=1 with beat 0 in the next cycle (latency 1).
//  SEND: o_data/o_keep/o_last hold stable while o_valid && !o_ready.
//   On a transfer that is not the last beat: beat+1, next beat presented next cycle.
//   On the last-beat transfer: if a new source is pending (see priority), load it
//   into active, set beat=0 and stay in SEND with no bubble. Otherwise go to IDLE
//   with o_valid=0.
//  o_keep = all ones except on the final beat, where only the low REM bits are set.
//   o_last=1 only on the final beat.
//  i_valid while in SEND, priority:
//   a) Last-beat transfer in the same cycle, shadow empty: i_data goes directly to active.
//   b) Last-beat transfer in the same cycle, shadow full: shadow goes to active, i_data to shadow.
//   c) No last-beat transfer, BUFFERED=1, shadow empty: i_data goes to shadow.
//   d) Any other case: i_data is dropped and overflow is set. Overflow clears only on reset or soft_reset.
//  BUFFERED=0: the shadow does not exist; cases b and c fall through to d.
//  Beat counter width = clog2(NUM_BEATS) (min 1). It wraps to 0 after the final beat only.
//  Word order: strictly ascending index. No duplication or loss under any o_ready pattern.
// TESTING
//  T1 NUM_WORDS=4,LANES=1,DW=16, i_data={4,3,2,1}, o_ready=1
//     -> o_valid 4 consecutive cycles from i_valid+1, o_data 1,2,3,4, o_last on 4th, then IDLE.
//  T2 As T1, o_ready=0 for 3 cycles while beat 2 is shown
//     -> o_data holds 2 for all 3 cycles, then 3,4; exactly 4 transfers total.
//  T3 NUM_WORDS=5,LANES=2, words 1..5
//     -> beats {2,1},{4,3},{0,5}, o_keep 11,11,01, o_last on 3rd beat.
//  T4 BUFFERED=1, vector B during beat 1 of A, vector C during beat 2 of A
//     -> 8 contiguous beats A then B with no bubble; C dropped, overflow=1, busy high throughout.
//  T5 s_axi_aresetn low mid-send at beat 2
//     -> o_valid=0 immediately (asynchronous), shadow empty after release.
//     soft_reset -> same result one edge later, and overflow cleared.
//  T6 BUFFERED=0, i_valid in the same cycle as the last-beat transfer
//     -> new vector beat 0 appears next cycle, overflow stays 0.
//     i_valid one cycle earlier -> dropped, overflow=1.

Source files
------------

// File: rtl/layer_stream_serializer.sv
// layer_stream_serializer
//   Captures a layer's parallel output vector (NUM_WORDS x DATA_WIDTH) and
//   streams it LANES words per beat over a valid/ready handshake.
//   The output carries a last-beat marker and a keep mask. When BUFFERED is
//   set, a one-deep shadow register holds the next vector. A sticky overflow
//   flag records any vector that had to be dropped.
// Ports
//   s_axi_aclk, s_axi_aresetn : clock, async active-low reset
//   soft_reset                : synchronous clear, same effect as reset
//   i_valid, i_data           : one-cycle capture strobe and vector (word 0 at LSBs)
//   o_data, o_keep, o_valid   : output beat (lane k = word beat*LANES+k), lane mask, valid
//   o_ready                   : sink accepts the current beat
//   o_last                    : final beat of the vector
//   busy                      : sending or shadow occupied
//   overflow                  : sticky, a vector was dropped
module layer_stream_serializer #(
  parameter int unsigned NUM_WORDS  = 30,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 1,
  parameter int unsigned BUFFERED   = 1
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic                            soft_reset,
  input  logic                            i_valid,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] i_data,
  output logic [LANES*DATA_WIDTH-1:0]     o_data,
  output logic [LANES-1:0]                o_keep,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic                            o_last,
  output logic                            busy,
  output logic                            overflow
);

  localparam int unsigned NUM_BEATS = (NUM_WORDS + LANES - 1) / LANES;
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned VEC_W     = NUM_WORDS * DATA_WIDTH;
  localparam int unsigned OUT_W     = LANES * DATA_WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic HAS_SHADOW = (BUFFERED != 0);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_q, state_n;
  logic [BEAT_W-1:0] beat_q, beat_n;
  logic [VEC_W-1:0]  active_q, active_n;
  logic [VEC_W-1:0]  shadow_q, shadow_n;
  logic              shadow_full_q, shadow_full_n;
  logic              overflow_n;
  logic [OUT_W-1:0]  data_n;
  logic [LANES-1:0]  keep_n;
  logic              last_n;
  logic              busy_n;
  logic              xfer;
  logic              last_xfer;
  logic [31:0]       idx;

  // o_valid mirrors state==SEND, so a transfer is simply SEND && o_ready
  assign xfer      = (state_q == S_SEND) && o_ready;
  assign last_xfer = xfer && (beat_q == LAST_BEAT);

  // Next-state, vector routing and next-cycle output beat
  always_comb begin
    state_n       = state_q;
    beat_n        = beat_q;
    active_n      = active_q;
    shadow_n      = shadow_q;
    shadow_full_n = shadow_full_q;
    overflow_n    = overflow;
    data_n        = '0;
    keep_n        = '0;
    last_n        = 1'b0;
    busy_n        = 1'b0;
    idx           = '0;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          active_n = i_data;
          beat_n   = '0;
          state_n  = S_SEND;
        end
      end
      default: begin
        if (last_xfer) begin
          beat_n = '0;
          if (shadow_full_q) begin
            // Shadow drains into active; a simultaneous new vector refills it
            active_n = shadow_q;
            if (i_valid) shadow_n = i_data;
            else         shadow_full_n = 1'b0;
          end else if (i_valid) begin
            active_n = i_data;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          if (xfer) beat_n = BEAT_W'(beat_q + 1'b1);
          if (i_valid) begin
            if (HAS_SHADOW && !shadow_full_q) begin
              shadow_n      = i_data;
              shadow_full_n = 1'b1;
            end else begin
              overflow_n = 1'b1;
            end
          end
        end
      end
    endcase

    if (soft_reset) begin
      state_n       = S_IDLE;
      beat_n        = '0;
      active_n      = '0;
      shadow_n      = '0;
      shadow_full_n = 1'b0;
      overflow_n    = 1'b0;
    end

    // Present the beat that will be on the bus after this edge; pad lanes stay 0
    if (state_n == S_SEND) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        idx = 32'(beat_n) * LANES + k;
        if (idx < NUM_WORDS) begin
          data_n[k*DATA_WIDTH +: DATA_WIDTH] = active_n[idx*DATA_WIDTH +: DATA_WIDTH];
          keep_n[k] = 1'b1;
        end
      end
      last_n = (beat_n == LAST_BEAT);
    end
    busy_n = (state_n == S_SEND) || shadow_full_n;
  end

  // State and registered outputs
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      overflow      <= 1'b0;
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_keep        <= '0;
      o_last        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_n;
      beat_q        <= beat_n;
      active_q      <= active_n;
      shadow_q      <= shadow_n;
      shadow_full_q <= shadow_full_n;
      overflow      <= overflow_n;
      o_valid       <= (state_n == S_SEND);
      o_data        <= data_n;
      o_keep        <= keep_n;
      o_last        <= last_n;
      busy          <= busy_n;
    end
  end

endmodule

// File: tb/tb_layer_stream_serializer.sv
// tb_layer_stream_serializer
//   Directed bench for layer_stream_serializer. Three instances cover
//   4x1 buffered, 5 words in 2 lanes, and 4x1 unbuffered configurations.
module tb_layer_stream_serializer;

  logic clk = 1'b0;
  logic rst_n;
  logic soft_reset;

  // u_a: NUM_WORDS=4, LANES=1, BUFFERED=1
  logic        a_iv, a_ov, a_rdy, a_last, a_busy, a_ovf;
  logic [63:0] a_id;
  logic [15:0] a_od;
  logic [0:0]  a_keep;
  // u_b: NUM_WORDS=5, LANES=2, BUFFERED=1
  logic        b_iv, b_ov, b_rdy, b_last, b_busy, b_ovf;
  logic [79:0] b_id;
  logic [31:0] b_od;
  logic [1:0]  b_keep;
  // u_c: NUM_WORDS=4, LANES=1, BUFFERED=0
  logic        c_iv, c_ov, c_rdy, c_last, c_busy, c_ovf;
  logic [63:0] c_id;
  logic [15:0] c_od;
  logic [0:0]  c_keep;

  int tests_run = 0;
  int tests_failed = 0;
  int a_xfers = 0;

  always #5 clk = ~clk;

  layer_stream_serializer #(.NUM_WORDS(4), .DATA_WIDTH(16), .LANES(1), .BUFFERED(1)) u_a (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
    .i_valid(a_iv), .i_data(a_id), .o_data(a_od), .o_keep(a_keep), .o_valid(a_ov),
    .o_ready(a_rdy), .o_last(a_last), .busy(a_busy), .overflow(a_ovf));

  layer_stream_serializer #(.NUM_WORDS(5), .DATA_WIDTH(16), .LANES(2), .BUFFERED(1)) u_b (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
    .i_valid(b_iv), .i_data(b_id), .o_data(b_od), .o_keep(b_keep), .o_valid(b_ov),
    .o_ready(b_rdy), .o_last(b_last), .busy(b_busy), .overflow(b_ovf));

  layer_stream_serializer #(.NUM_WORDS(4), .DATA_WIDTH(16), .LANES(1), .BUFFERED(0)) u_c (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
    .i_valid(c_iv), .i_data(c_id), .o_data(c_od), .o_keep(c_keep), .o_valid(c_ov),
    .o_ready(c_rdy), .o_last(c_last), .busy(c_busy), .overflow(c_ovf));

  // Handshake counter for u_a
  always @(posedge clk) if (a_ov && a_rdy) a_xfers <= a_xfers + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect u_a to present one word beat
  task automatic a_beat(input string tag, input logic [15:0] w, input logic last);
    check({tag, "_valid"}, 64'(a_ov), 64'(1));
    check({tag, "_data"}, 64'(a_od), 64'(w));
    check({tag, "_last"}, 64'(a_last), 64'(last));
  endtask

  task automatic c_beat(input string tag, input logic [15:0] w, input logic last);
    check({tag, "_valid"}, 64'(c_ov), 64'(1));
    check({tag, "_data"}, 64'(c_od), 64'(w));
    check({tag, "_last"}, 64'(c_last), 64'(last));
  endtask

  initial begin
    rst_n = 1'b0; soft_reset = 1'b0;
    a_iv = 0; a_id = '0; a_rdy = 1;
    b_iv = 0; b_id = '0; b_rdy = 1;
    c_iv = 0; c_id = '0; c_rdy = 1;
    #12;
    check("rst_valid", 64'(a_ov), 64'(0));
    check("rst_keep", 64'(a_keep), 64'(0));
    check("rst_data", 64'(b_od), 64'(0));
    check("rst_busy", 64'(c_busy), 64'(0));
    check("rst_ovf", 64'(a_ovf), 64'(0));
    rst_n = 1'b1;
    tick();

    // T1: 4 words, always ready
    a_id = {16'd4, 16'd3, 16'd2, 16'd1}; a_iv = 1;
    tick(); a_iv = 0;
    a_beat("t1_b0", 16'd1, 1'b0);
    check("t1_keep", 64'(a_keep), 64'(1));
    check("t1_busy", 64'(a_busy), 64'(1));
    tick(); a_beat("t1_b1", 16'd2, 1'b0);
    tick(); a_beat("t1_b2", 16'd3, 1'b0);
    tick(); a_beat("t1_b3", 16'd4, 1'b1);
    tick();
    check("t1_idle", 64'(a_ov), 64'(0));
    check("t1_idle_busy", 64'(a_busy), 64'(0));

    // T2: stall 3 cycles on beat 2
    a_xfers = 0;
    a_iv = 1;
    tick(); a_iv = 0;
    a_beat("t2_b0", 16'd1, 1'b0);
    tick(); a_beat("t2_b1", 16'd2, 1'b0);
    a_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); a_beat("t2_hold", 16'd2, 1'b0);
    end
    a_rdy = 1;
    tick(); a_beat("t2_b2", 16'd3, 1'b0);
    tick(); a_beat("t2_b3", 16'd4, 1'b1);
    tick();
    check("t2_idle", 64'(a_ov), 64'(0));
    check("t2_xfers", 64'(a_xfers), 64'(4));

    // T3: 5 words over 2 lanes
    b_id = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}; b_iv = 1;
    tick(); b_iv = 0;
    check("t3_b0_data", 64'(b_od), 64'h0002_0001);
    check("t3_b0_keep", 64'(b_keep), 64'b11);
    check("t3_b0_last", 64'(b_last), 64'(0));
    tick();
    check("t3_b1_data", 64'(b_od), 64'h0004_0003);
    check("t3_b1_keep", 64'(b_keep), 64'b11);
    check("t3_b1_last", 64'(b_last), 64'(0));
    tick();
    check("t3_b2_data", 64'(b_od), 64'h0000_0005);
    check("t3_b2_keep", 64'(b_keep), 64'b01);
    check("t3_b2_last", 64'(b_last), 64'(1));
    tick();
    check("t3_idle", 64'(b_ov), 64'(0));

    // T4: A, then B into shadow during beat 1, C dropped during beat 2
    a_id = {16'h14, 16'h13, 16'h12, 16'h11}; a_iv = 1;
    tick(); a_iv = 0;
    a_beat("t4_a0", 16'h11, 1'b0);
    tick(); a_beat("t4_a1", 16'h12, 1'b0);
    a_id = {16'h24, 16'h23, 16'h22, 16'h21}; a_iv = 1;
    tick(); a_beat("t4_a2", 16'h13, 1'b0);
    check("t4_ovf_b", 64'(a_ovf), 64'(0));
    a_id = {16'h34, 16'h33, 16'h32, 16'h31}; a_iv = 1;
    tick(); a_iv = 0;
    a_beat("t4_a3", 16'h14, 1'b1);
    check("t4_ovf_c", 64'(a_ovf), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      a_beat("t4_b", 16'(16'h21 + i), (i == 3));
      check("t4_busy", 64'(a_busy), 64'(1));
    end
    tick();
    check("t4_idle", 64'(a_ov), 64'(0));
    check("t4_ovf_sticky", 64'(a_ovf), 64'(1));

    // T5a: async reset at beat 2 with shadow occupied
    a_id = {16'h44, 16'h43, 16'h42, 16'h41}; a_iv = 1;
    tick(); a_iv = 0;
    tick();
    a_id = {16'h54, 16'h53, 16'h52, 16'h51}; a_iv = 1;
    tick(); a_iv = 0;
    a_beat("t5_pre", 16'h43, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(a_ov), 64'(0));
    check("t5_async_ovf", 64'(a_ovf), 64'(0));
    #1 rst_n = 1'b1;
    tick();
    check("t5_post_valid", 64'(a_ov), 64'(0));
    check("t5_post_busy", 64'(a_busy), 64'(0));

    // T5b: soft reset with shadow full and overflow set
    a_iv = 1;
    tick();
    tick();
    tick(); a_iv = 0;
    check("t5s_ovf_set", 64'(a_ovf), 64'(1));
    soft_reset = 1'b1;
    #2;
    check("t5s_before_edge", 64'(a_ov), 64'(1));
    tick(); soft_reset = 1'b0;
    check("t5s_valid", 64'(a_ov), 64'(0));
    check("t5s_busy", 64'(a_busy), 64'(0));
    check("t5s_ovf", 64'(a_ovf), 64'(0));
    tick();
    check("t5s_stay_idle", 64'(a_ov), 64'(0));

    // T6: unbuffered, back-to-back on the last-beat transfer, then an early drop
    c_id = {16'h14, 16'h13, 16'h12, 16'h11}; c_iv = 1;
    tick(); c_iv = 0;
    c_beat("t6_a0", 16'h11, 1'b0);
    tick(); tick();
    tick(); c_beat("t6_a3", 16'h14, 1'b1);
    c_id = {16'h24, 16'h23, 16'h22, 16'h21}; c_iv = 1;
    tick(); c_iv = 0;
    c_beat("t6_b0", 16'h21, 1'b0);
    check("t6_ovf0", 64'(c_ovf), 64'(0));
    tick(); tick();
    c_beat("t6_b2", 16'h23, 1'b0);
    c_id = {16'h34, 16'h33, 16'h32, 16'h31}; c_iv = 1;
    tick(); c_iv = 0;
    c_beat("t6_b3", 16'h24, 1'b1);
    check("t6_ovf1", 64'(c_ovf), 64'(1));
    tick();
    check("t6_idle", 64'(c_ov), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
